// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory for the load/store path: valid/ready requests,
// sized and lane-aligned accesses, error reporting, configurable read latency, post-reset clear.
module data_mem_ctrl #(
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-3:0] LAST_W = (ADDR_WIDTH-2)'(DEPTH - 1);
    localparam logic [IW-1:0]         LAST_I = IW'(DEPTH - 1);

    typedef enum logic {
        S_INIT,
        S_IDLE
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   clr_idx_q;
    logic            ready_q;

    logic [31:0]     mem_q [DEPTH];

    logic [ADDR_WIDTH-3:0] widx;
    logic [1:0]            lane;
    logic [IW-1:0]         midx;
    logic                  in_range;
    logic                  accept;
    logic                  err_d;
    logic                  wr_en;
    logic [3:0]            be_d;
    logic [31:0]           wlane_d;
    logic [31:0]           rword;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;
    logic [31:0]           ldata_d;
    logic [31:0]           rdata_d;

    logic                  pv_q [READ_LATENCY];
    logic [31:0]           pd_q [READ_LATENCY];
    logic                  pe_q [READ_LATENCY];

    assign widx     = req_addr[ADDR_WIDTH-1:2];
    assign lane     = req_addr[1:0];
    assign midx     = widx[IW-1:0];
    assign in_range = (widx <= LAST_W);
    assign accept   = req_valid & ready_q;
    assign wr_en    = accept & req_we & ~err_d;

    always_comb begin
        err_d = 1'b0;
        case (req_size)
            2'b00:   err_d = 1'b0;
            2'b01:   err_d = lane[0];
            2'b10:   err_d = (lane != 2'b00);
            default: err_d = 1'b1;
        endcase
        if (!in_range) err_d = 1'b1;
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        be_d    = 4'b0000;
        wlane_d = '0;
        case (req_size)
            2'b00: begin
                be_d    = 4'b0001 << lane;
                wlane_d = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_d    = lane[1] ? 4'b1100 : 4'b0011;
                wlane_d = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                be_d    = 4'b1111;
                wlane_d = req_wdata;
            end
            default: begin
                be_d    = 4'b0000;
                wlane_d = '0;
            end
        endcase
    end

    always_comb begin
        rword   = in_range ? mem_q[midx] : '0;
        rbyte   = rword[{lane, 3'b000} +: 8];
        rhalf   = rword[{lane[1], 4'b0000} +: 16];
        ldata_d = rword;
        case (req_size)
            2'b00:   ldata_d = {{24{rbyte[7] & ~req_unsigned}}, rbyte};
            2'b01:   ldata_d = {{16{rhalf[15] & ~req_unsigned}}, rhalf};
            default: ldata_d = rword;
        endcase
        rdata_d = (err_d || req_we) ? '0 : ldata_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? S_INIT : S_IDLE;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == LAST_I) begin
                        state_q   <= S_IDLE;
                        ready_q   <= 1'b1;
                        clr_idx_q <= '0;
                    end
                end
                S_IDLE: ready_q <= 1'b1;
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem_q[clr_idx_q] <= '0;
        end else if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_d[b]) mem_q[midx][8*b +: 8] <= wlane_d[8*b +: 8];
            end
        end
    end

    // Data registers only load behind a valid beat so the outputs hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pv_q[i] <= 1'b0;
                pd_q[i] <= '0;
                pe_q[i] <= 1'b0;
            end
        end else begin
            pv_q[0] <= accept;
            if (accept) begin
                pd_q[0] <= rdata_d;
                pe_q[0] <= err_d;
            end
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                if (pv_q[i-1]) begin
                    pd_q[i] <= pd_q[i-1];
                    pe_q[i] <= pe_q[i-1];
                end
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = pv_q[READ_LATENCY-1];
    assign rsp_rdata = pd_q[READ_LATENCY-1];
    assign rsp_err   = pe_q[READ_LATENCY-1];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: byte-array reference model with a per-cycle response checker,
// directed literal cases and randomized traffic.
module tb_data_mem_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 32;
    localparam int unsigned RL    = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    data_mem_ctrl #(
        .DEPTH(DEPTH),
        .ADDR_WIDTH(AW),
        .READ_LATENCY(RL),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        err;
        bit          has_lit;
        logic [31:0] lit_rd;
        logic        lit_err;
    } exp_t;

    exp_t        q[$];
    int          pulses[$];
    logic [7:0]  mb [DEPTH*4];
    int          cyc = 0;
    int unsigned init_cnt = 0;
    bit          model_ready = 1'b0;
    bit          lit_pend = 1'b0;
    logic [31:0] lit_rd;
    logic        lit_err;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte array, updated at each accepting edge.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            init_cnt    = 0;
            model_ready = 1'b0;
        end else begin
            cyc++;
            if (model_ready && req_valid) begin
                exp_t        e;
                int unsigned wi, ln, n, base;
                bit          err;
                logic [31:0] v;
                e.due     = cyc + int'(RL) - 1;
                e.has_lit = lit_pend;
                e.lit_rd  = lit_rd;
                e.lit_err = lit_err;
                lit_pend  = 1'b0;
                wi   = req_addr >> 2;
                ln   = req_addr & 32'd3;
                n    = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
                err  = (req_size == 2'd3) || (ln % n != 0) || (wi >= DEPTH);
                base = wi * 4 + ln;
                v    = '0;
                if (err) begin
                    e.rd = '0; e.err = 1'b1;
                end else if (req_we) begin
                    for (int unsigned k = 0; k < n; k++) mb[base+k] = 8'(req_wdata >> (8*k));
                    e.rd = '0; e.err = 1'b0;
                end else begin
                    for (int unsigned k = 0; k < n; k++) v = v | (32'(mb[base+k]) << (8*k));
                    if (!req_unsigned && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                    e.rd = v; e.err = 1'b0;
                end
                q.push_back(e);
            end
            if (!model_ready) begin
                init_cnt++;
                if (init_cnt == DEPTH) begin
                    model_ready = 1'b1;
                    for (int unsigned k = 0; k < DEPTH*4; k++) mb[k] = 8'h00;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_valid", 32'(rsp_valid), 32'd0);
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_rdata", rsp_rdata, 32'd0);
        end else begin
            bit   exp_v;
            exp_t ce;
            chk("ready", 32'(req_ready), 32'(model_ready));
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
            if (rsp_valid) pulses.push_back(cyc);
            if (exp_v) begin
                ce = q.pop_front();
                chk("rsp_rdata", rsp_rdata, ce.rd);
                chk("rsp_err", 32'(rsp_err), 32'(ce.err));
                if (ce.has_lit) begin
                    chk("lit_rdata", rsp_rdata, ce.lit_rd);
                    chk("lit_err", 32'(rsp_err), 32'(ce.lit_err));
                end
            end
        end
    end

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [1:0] sz,
                          input bit uns, input logic [31:0] wd,
                          input logic [31:0] lrd, input bit lerr);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = sz;
        req_unsigned = uns;
        req_wdata    = wd;
        lit_pend     = 1'b1;
        lit_rd       = lrd;
        lit_err      = lerr;
        @(negedge clk);
        req_valid    = 1'b0;
        lit_pend     = 1'b0;
    endtask

    task automatic measure_init();
        int unsigned n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("init_len", n, 32'd16);
    endtask

    task automatic assert_reset();
        #2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        lit_pend  = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int a;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = '0;
        lit_rd = '0; lit_err = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        measure_init();

        do_req(0, 32'h3C, 2'd2, 0, 0, 32'h0000_0000, 0);
        do_req(1, 32'h08, 2'd2, 0, 32'hDEAD_BEEF, 32'h0, 0);
        do_req(0, 32'h0B, 2'd0, 0, 0, 32'hFFFF_FFDE, 0);
        do_req(0, 32'h0B, 2'd0, 1, 0, 32'h0000_00DE, 0);
        do_req(0, 32'h0A, 2'd1, 0, 0, 32'hFFFF_DEAD, 0);
        do_req(0, 32'h08, 2'd1, 1, 0, 32'h0000_BEEF, 0);
        do_req(1, 32'h09, 2'd0, 0, 32'hAAAA_AA11, 32'h0, 0);
        do_req(0, 32'h08, 2'd2, 0, 0, 32'hDEAD_11EF, 0);
        do_req(1, 32'h0A, 2'd1, 0, 32'h5555_7777, 32'h0, 0);
        do_req(0, 32'h08, 2'd2, 0, 0, 32'h7777_11EF, 0);
        do_req(0, 32'h02, 2'd2, 0, 0, 32'h0, 1);
        do_req(0, 32'h01, 2'd1, 0, 0, 32'h0, 1);
        do_req(0, 32'h08, 2'd3, 0, 0, 32'h0, 1);
        do_req(0, 32'h40, 2'd2, 0, 0, 32'h0, 1);
        do_req(1, 32'h08, 2'd3, 0, 32'h1234_5678, 32'h0, 1);
        do_req(1, 32'h0A, 2'd2, 0, 32'h1234_5678, 32'h0, 1);
        do_req(1, 32'h40, 2'd2, 0, 32'h1234_5678, 32'h0, 1);
        do_req(0, 32'h08, 2'd2, 0, 0, 32'h7777_11EF, 0);
        idle(RL + 2);

        pulses.delete();
        do_req(1, 32'h00, 2'd2, 0, 32'h0000_0005, 32'h0, 0);
        a = cyc;
        do_req(0, 32'h00, 2'd2, 0, 0, 32'h0000_0005, 0);
        idle(RL + 2);
        if (pulses.size() != 2) begin
            chk("b2b_count", pulses.size(), 32'd2);
        end else begin
            chk("b2b_lat0", 32'(pulses[0] - a + 1), 32'd3);
            chk("b2b_lat1", 32'(pulses[1] - a + 1), 32'd4);
        end

        #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        pulses.delete();
        assert_reset();
        measure_init();
        chk("midinit_pulses", pulses.size(), 32'd0);

        do_req(1, 32'h04, 2'd2, 0, 32'hCAFE_F00D, 32'h0, 0);
        idle(RL + 1);
        do_req(0, 32'h04, 2'd2, 0, 0, 32'hCAFE_F00D, 0);
        do_req(0, 32'h00, 2'd2, 0, 0, 32'h0, 0);
        pulses.delete();
        assert_reset();
        measure_init();
        chk("inflight_pulses", pulses.size(), 32'd0);
        do_req(0, 32'h04, 2'd2, 0, 0, 32'h0000_0000, 0);
        idle(RL + 1);

        for (int it = 0; it < 1500; it++) begin
            int unsigned wi, ln, r;
            logic [1:0]  sz;
            logic [31:0] ad;
            wi = $urandom_range(0, DEPTH + 1);
            ln = $urandom_range(0, 3);
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) ln = ln & 2;
                if (sz == 2'd2) ln = 0;
            end
            ad = wi * 4 + ln;
            if ($urandom_range(0, 19) == 0) ad = ad | 32'h8000_0000;
            req_valid    = ($urandom_range(0, 3) != 0);
            req_we       = $urandom_range(0, 1) == 1;
            req_addr     = ad;
            req_size     = sz;
            req_unsigned = $urandom_range(0, 1) == 1;
            req_wdata    = $urandom;
            @(negedge clk);
        end
        req_valid = 1'b0;
        idle(RL + 2);
        chk("drain", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
